// File: rtl/pic16_pkg.sv
// Shared constants and helpers for the PIC16F fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pic16_pkg;

    localparam int ADDR_WIDTH  = 13;
    localparam int STACK_DEPTH = 8;

    localparam logic [12:0] RESET_VECTOR = 13'h0000;
    localparam logic [12:0] INT_VECTOR   = 13'h0004;

    // Source selected for the next PC, listed in decreasing priority after HOLD/INC.
    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_IRQ  = 3'd2,
        SEL_RET  = 3'd3,
        SEL_CALL = 3'd4,
        SEL_GOTO = 3'd5,
        SEL_PCL  = 3'd6
    } pc_sel_e;

    // Return-stack request issued by the PC mux; push and pop are never both set.
    typedef struct packed {
        logic push;
        logic pop;
    } stk_op_t;

    // GOTO/CALL target: upper two page bits come from PCLATH, the rest from the opcode.
    function automatic logic [12:0] page_addr(input logic [4:0] pclath, input logic [10:0] lit11);
        return {pclath[4:3], lit11};
    endfunction

    // Computed jump target: full PCLATH on top of the byte written to PCL.
    function automatic logic [12:0] pcl_addr(input logic [4:0] pclath, input logic [7:0] pcl_data);
        return {pclath, pcl_data};
    endfunction

endpackage

// File: rtl/pc_stack.sv
// Circular LIFO of return addresses; rd_data always shows the entry a pop would return.
// Latency: push/pop take effect at the next rising edge; rd_data is combinational from the stack.
// Backpressure: none; overflow overwrites the oldest entry and underflow returns stale data.
// Build option: STACK_STATUS_EN adds a saturating valid counter and sticky stk_ovf/stk_unf.
module pc_stack
    import pic16_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
`ifdef STACK_STATUS_EN
    ,
    output logic             stk_ovf,
    output logic             stk_unf
`endif
);

    // DEPTH is a power of two, so the pointer wraps naturally.
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_dec;

    // ptr_q points at the next free slot; the top of stack sits one below it.
    assign ptr_dec = ptr_q - PW'(1);
    assign rd_data = mem_q[ptr_dec];

    // Stack pointer: push advances, pop retreats; push wins if both ever arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PW'(1);
        end else if (pop) begin
            ptr_q <= ptr_dec;
        end
    end

    // Entry storage: cleared on reset so an early pop returns address zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

`ifdef STACK_STATUS_EN
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW:0] cnt_q;
    logic        ovf_q;
    logic        unf_q;

    // Valid-entry counter saturating at 0..DEPTH; flags latch until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push) begin
            if (cnt_q == CNT_FULL) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end
        end else if (pop) begin
            if (cnt_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - (PW+1)'(1);
            end
        end
    end

    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`endif

endmodule

// File: rtl/program_counter.sv
// Fetch-stage PC: priority redirect mux, PC register, one-cycle flush pulse and return stack.
// Latency: new PC appears on addr one cycle after the deciding edge; flush is high for that cycle.
// Backpressure: stall freezes sequential increment only; redirects are always taken. rd_en = ~stall.
// Build option: STACK_STATUS_EN adds sticky stk_ovf/stk_unf return-stack status outputs.
module program_counter
    import pic16_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = pic16_pkg::ADDR_WIDTH,
    parameter int                    STACK_DEPTH = pic16_pkg::STACK_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] INT_VECTOR  = ADDR_WIDTH'(pic16_pkg::INT_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  ld_goto,
    input  logic                  ld_call,
    input  logic                  ld_ret,
    input  logic                  ld_pcl,
    input  logic                  irq,
    input  logic [10:0]           lit11,
    input  logic [4:0]            pclath,
    input  logic [7:0]            pcl_data,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  rd_en,
    output logic                  flush,
    output logic [7:0]            pcl_out
`ifdef STACK_STATUS_EN
    ,
    output logic                  stk_ovf,
    output logic                  stk_unf
`endif
);

    pc_sel_e               sel;
    stk_op_t               stk_op;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] stk_rd_data;
    logic                  flush_q;

    // Resolve the next-PC source: irq > ret > call > goto > pcl > increment/hold.
    always_comb begin
        sel = SEL_INC;
        if (irq) begin
            sel = SEL_IRQ;
        end else if (ld_ret) begin
            sel = SEL_RET;
        end else if (ld_call) begin
            sel = SEL_CALL;
        end else if (ld_goto) begin
            sel = SEL_GOTO;
        end else if (ld_pcl) begin
            sel = SEL_PCL;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    // Stack traffic follows the winning source, so a losing ret or call never touches the stack.
    always_comb begin
        stk_op      = '0;
        stk_op.push = (sel == SEL_IRQ) || (sel == SEL_CALL);
        stk_op.pop  = (sel == SEL_RET);
        redirect    = (sel != SEL_INC) && (sel != SEL_HOLD);
    end

    // Next-PC value per source; increment wraps at the top of program memory.
    always_comb begin
        pc_nxt = pc_q;
        unique case (sel)
            SEL_IRQ:  pc_nxt = INT_VECTOR;
            SEL_RET:  pc_nxt = stk_rd_data;
            SEL_CALL: pc_nxt = ADDR_WIDTH'(page_addr(pclath, lit11));
            SEL_GOTO: pc_nxt = ADDR_WIDTH'(page_addr(pclath, lit11));
            SEL_PCL:  pc_nxt = ADDR_WIDTH'(pcl_addr(pclath, pcl_data));
            SEL_INC:  pc_nxt = pc_q + ADDR_WIDTH'(1);
            SEL_HOLD: pc_nxt = pc_q;
            default:  pc_nxt = pc_q;
        endcase
    end

    // PC and flush registers; flush marks the first fetch at a redirected address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            flush_q <= redirect;
        end
    end

    // The pushed return address is the current PC, which already points past the call.
    pc_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (stk_op.push),
        .pop     (stk_op.pop),
        .wr_data (pc_q),
        .rd_data (stk_rd_data)
`ifdef STACK_STATUS_EN
        ,
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
`endif
    );

    assign addr    = pc_q;
    assign flush   = flush_q;
    assign rd_en   = ~stall;
    assign pcl_out = pc_q[7:0];

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed scenarios with literal expectations, then randomized traffic.
// A behavioural model tracks PC, flush and the circular stack; a compare process checks every negedge.
// Build option: STACK_STATUS_EN also checks stk_ovf/stk_unf.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, ld_goto, ld_call, ld_ret, ld_pcl, irq;
    logic [10:0] lit11;
    logic [4:0]  pclath;
    logic [7:0]  pcl_data;
    logic [12:0] addr;
    logic        rd_en, flush;
    logic [7:0]  pcl_out;
`ifdef STACK_STATUS_EN
    logic        stk_ovf, stk_unf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    program_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .ld_goto  (ld_goto),
        .ld_call  (ld_call),
        .ld_ret   (ld_ret),
        .ld_pcl   (ld_pcl),
        .irq      (irq),
        .lit11    (lit11),
        .pclath   (pclath),
        .pcl_data (pcl_data),
        .addr     (addr),
        .rd_en    (rd_en),
        .flush    (flush),
        .pcl_out  (pcl_out)
`ifdef STACK_STATUS_EN
        ,
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
`endif
    );

    // ---------------- behavioural model ----------------
    int m_pc;
    int m_sp;
    int m_cnt;
    int m_stk [8];
    bit m_flush, m_ovf, m_unf;

    // Model state advances on the same edge as the DUT, from the architectural rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 0;
            m_sp    <= 0;
            m_cnt   <= 0;
            m_flush <= 1'b0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
            for (int k = 0; k < 8; k++) m_stk[k] <= 0;
        end else begin
            m_flush <= irq | ld_ret | ld_call | ld_goto | ld_pcl;
            if (irq || (!ld_ret && ld_call)) begin
                m_stk[m_sp] <= m_pc;
                m_sp        <= (m_sp + 1) % 8;
                m_cnt       <= (m_cnt < 8) ? m_cnt + 1 : 8;
                if (m_cnt == 8) m_ovf <= 1'b1;
                m_pc        <= irq ? 4 : ((int'(pclath) >> 3) * 2048 + int'(lit11));
            end else if (ld_ret) begin
                m_sp  <= (m_sp + 7) % 8;
                m_pc  <= m_stk[(m_sp + 7) % 8];
                m_cnt <= (m_cnt > 0) ? m_cnt - 1 : 0;
                if (m_cnt == 0) m_unf <= 1'b1;
            end else if (ld_goto) begin
                m_pc <= (int'(pclath) >> 3) * 2048 + int'(lit11);
            end else if (ld_pcl) begin
                m_pc <= int'(pclath) * 256 + int'(pcl_data);
            end else if (!stall) begin
                m_pc <= (m_pc + 1) % 8192;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_addr",    32'(addr),    32'(m_pc));
            chk("cyc_flush",   32'(flush),   32'(m_flush));
            chk("cyc_pcl_out", 32'(pcl_out), 32'(m_pc % 256));
            chk("cyc_rd_en",   32'(rd_en),   32'(!stall));
`ifdef STACK_STATUS_EN
            chk("cyc_stk_ovf", 32'(stk_ovf), 32'(m_ovf));
            chk("cyc_stk_unf", 32'(stk_unf), 32'(m_unf));
`endif
        end
    end

    // Apply one cycle of inputs (caller sits just after a rising edge), then move past the next edge.
    task automatic step(input bit s = 0, input bit g = 0, input bit c = 0, input bit r = 0,
                        input bit p = 0, input bit i = 0,
                        input int lt = 0, input int pl = 0, input int pd = 0);
        stall    = s;
        ld_goto  = g;
        ld_call  = c;
        ld_ret   = r;
        ld_pcl   = p;
        irq      = i;
        lit11    = lt[10:0];
        pclath   = pl[4:0];
        pcl_data = pd[7:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ret;
        rst_n = 1'b0;
        step(.s(1));
        step(.s(1));
        chk("rst_addr",    32'(addr),    32'h0);
        chk("rst_flush",   32'(flush),   32'h0);
        chk("rst_pcl_out", 32'(pcl_out), 32'h0);
        chk("rst_rd_en_stalled", 32'(rd_en), 32'h0);
        stall = 1'b0;
        #1;
        chk("rst_rd_en_free", 32'(rd_en), 32'h1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Free running from the reset vector.
        chk("free_addr0", 32'(addr), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("free_addr", 32'(addr), 32'(k));
            chk("free_flush", 32'(flush), 32'h0);
        end

        // Increment wraps at the top of program memory without flushing.
        step(.p(1), .pl(5'h1F), .pd(8'hFF));
        chk("wrap_setup", 32'(addr), 32'h1FFF);
        step();
        chk("wrap_addr", 32'(addr), 32'h0000);
        chk("wrap_flush", 32'(flush), 32'h0);

        // GOTO takes the page bits from PCLATH[4:3]; flush lasts one cycle.
        step(.p(1), .pd(8'h10));
        step(.g(1), .pl(5'h18), .lt(11'h123));
        chk("goto_addr", 32'(addr), 32'h1923);
        chk("goto_flush", 32'(flush), 32'h1);
        step();
        chk("goto_next_addr", 32'(addr), 32'h1924);
        chk("goto_next_flush", 32'(flush), 32'h0);

        // CALL then RETURN comes back to the address following the call site.
        step(.p(1), .pd(8'h21));
        step(.c(1), .lt(11'h050));
        chk("call_addr", 32'(addr), 32'h0050);
        step(.r(1));
        chk("ret_addr", 32'(addr), 32'h0021);
        chk("ret_flush", 32'(flush), 32'h1);

        // Nine nested calls overflow the 8-entry stack; the 9th push lands on entry 0.
        for (int k = 0; k < 9; k++) begin
            step(.c(1), .lt(11'h100 + k * 16));
`ifdef STACK_STATUS_EN
            if (k == 7) chk("ovf_after_8", 32'(stk_ovf), 32'h0);
            if (k == 8) chk("ovf_after_9", 32'(stk_ovf), 32'h1);
`endif
        end
        for (int j = 1; j <= 9; j++) begin
            step(.r(1));
            // Pop j returns the value of push (10-j) for j<=8, and pop 9 re-reads entry 0 (push 9).
            exp_ret = (j == 1 || j == 9) ? 32'h170 : 32'h100 + (8 - j) * 16;
            chk("nest_ret", 32'(addr), 32'(exp_ret));
`ifdef STACK_STATUS_EN
            if (j == 8) chk("unf_after_8", 32'(stk_unf), 32'h0);
            if (j == 9) chk("unf_after_9", 32'(stk_unf), 32'h1);
`endif
        end

        // irq beats a same-cycle return: no pop, PC pushed, vector taken.
        step(.p(1), .pd(8'h42));
        step(.i(1), .r(1));
        chk("irq_addr", 32'(addr), 32'h0004);
        chk("irq_flush", 32'(flush), 32'h1);
        step(.r(1));
        chk("irq_ret_addr", 32'(addr), 32'h0042);

        // A PCL write during stall is still taken and still flushes.
        step(.s(1), .p(1), .pd(8'h80));
        chk("stall_pcl_addr", 32'(addr), 32'h0080);
        chk("stall_pcl_flush", 32'(flush), 32'h1);
        chk("stall_pcl_rd_en", 32'(rd_en), 32'h0);
        step(.s(1));
        chk("stall_hold_addr", 32'(addr), 32'h0080);
        chk("stall_hold_flush", 32'(flush), 32'h0);

        // Asynchronous reset in the middle of a call clears PC and stack at once.
        step(.c(1), .lt(11'h300));
        step(.c(1), .lt(11'h310));
        stall   = 1'b0;
        ld_call = 1'b1;
        lit11   = 11'h320;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(addr), 32'h0);
        chk("arst_flush", 32'(flush), 32'h0);
        @(posedge clk);
        #1;
        ld_call = 1'b0;
        rst_n   = 1'b1;
        step(.r(1));
        chk("arst_stack_cleared", 32'(addr), 32'h0);

        // Randomized traffic; stall is kept away from stack operations.
        for (int n = 0; n < 3000; n++) begin
            bit s, g, c, r, p, i;
            s = ($urandom_range(0, 99) < 20);
            g = ($urandom_range(0, 99) < 8);
            c = ($urandom_range(0, 99) < 8);
            r = ($urandom_range(0, 99) < 8);
            p = ($urandom_range(0, 99) < 8);
            i = ($urandom_range(0, 99) < 4);
            if (s) begin
                c = 1'b0;
                r = 1'b0;
                i = 1'b0;
            end
            step(.s(s), .g(g), .c(c), .r(r), .p(p), .i(i),
                 .lt(int'($urandom_range(0, 2047))), .pl(int'($urandom_range(0, 31))),
                 .pd(int'($urandom_range(0, 255))));
        end

        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
